alu_op_sequencer: RTL and testbench

Sequential command front end for the combinational `BreadBoard` ALU. It accepts one operation at a time over a valid/ready command port and drives the ALU's `input1`/`input2`/`opcode` from registers. After a programmable settle window it captures `result`/`error` and returns them, tagged, over a valid/ready response port. It also keeps operation and error counters for the host.

---
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command front end for the combinational BreadBoard ALU. Accepts one
// operation at a time, holds the ALU operands for a programmable settle
// window, captures result/error and returns them tagged to the host.
// Keeps completed-operation and error counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready=1, waiting for a command
// DRIVE   | ALU inputs held, settle counter running down to capture
// RESPOND | rsp_valid=1, response held until the host takes it

module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic [15:0] alu_input1,
  output logic [15:0] alu_input2,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_error,
  output logic [3:0]  rsp_tag,
  output logic        busy,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       cmd_legal;

  // Opcodes 1..5 are the ALU operations; everything else is answered locally.
  assign cmd_legal = (cmd_opcode >= 4'd1) && (cmd_opcode <= 4'd5);

  // Sequencer FSM with registered handshake, ALU-drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      alu_input1 <= 16'd0;
      alu_input2 <= 16'd0;
      alu_opcode <= 4'd0;
      rsp_result <= 32'd0;
      rsp_error  <= 2'b00;
      rsp_tag    <= 4'd0;
      op_count   <= 16'd0;
      err_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rsp_tag   <= cmd_tag;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_legal) begin
              alu_input1 <= cmd_a;
              alu_input2 <= cmd_b;
              alu_opcode <= cmd_opcode;
              settle_cnt <= SETTLE_LOAD;
              state      <= DRIVE;
            end else begin
              // Illegal opcode: the ALU keeps its previous inputs.
              rsp_result <= 32'd0;
              rsp_error  <= 2'b11;
              rsp_valid  <= 1'b1;
              state      <= RESPOND;
            end
          end
        end

        DRIVE: begin
          // A count of 0 can only come from an out-of-range parameter;
          // treat it like 1 so the FSM never stalls.
          if (settle_cnt <= 4'd1) begin
            rsp_result <= alu_result;
            rsp_error  <= alu_error;
            rsp_valid  <= 1'b1;
            state      <= RESPOND;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        RESPOND: begin
          if (rsp_ready) begin
            op_count <= op_count + 16'd1;
            if ((rsp_error != 2'b00) && (err_count != 8'hFF))
              err_count <= err_count + 8'd1;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with SETTLE_CYCLES=1
// for the functional sequence and one with SETTLE_CYCLES=4 for the
// mid-operation reset case. A behavioral ALU stub feeds both.

module tb_alu_op_sequencer;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  err;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, d4_rst_n;
  logic        cmd_valid, d4_cmd_valid;
  logic [3:0]  cmd_opcode, cmd_tag;
  logic [15:0] cmd_a, cmd_b;
  logic        rsp_ready;

  logic        cmd_ready, rsp_valid, busy;
  logic [15:0] alu_input1, alu_input2, op_count;
  logic [3:0]  alu_opcode, rsp_tag;
  logic [31:0] alu_result, rsp_result;
  logic [1:0]  alu_error, rsp_error;
  logic [7:0]  err_count;

  logic        d4_cmd_ready, d4_rsp_valid, d4_busy;
  logic [15:0] d4_alu_input1, d4_alu_input2, d4_op_count;
  logic [3:0]  d4_alu_opcode, d4_rsp_tag;
  logic [31:0] d4_alu_result, d4_rsp_result;
  logic [1:0]  d4_alu_error, d4_rsp_error;
  logic [7:0]  d4_err_count;

  int   checks = 0;
  int   errors = 0;
  int   exp_ops = 0;
  int   exp_errs = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag), .busy(busy),
    .op_count(op_count), .err_count(err_count)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(d4_rst_n),
    .cmd_valid(d4_cmd_valid), .cmd_ready(d4_cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_input1(d4_alu_input1), .alu_input2(d4_alu_input2), .alu_opcode(d4_alu_opcode),
    .alu_result(d4_alu_result), .alu_error(d4_alu_error),
    .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(d4_rsp_result),
    .rsp_error(d4_rsp_error), .rsp_tag(d4_rsp_tag), .busy(d4_busy),
    .op_count(d4_op_count), .err_count(d4_err_count)
  );

  // Behavioral stand-in for the BreadBoard ALU: {error, result}.
  function automatic logic [33:0] alu_model(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] wa, wb;
    wa = {16'd0, a};
    wb = {16'd0, b};
    case (op)
      4'd1: return {2'b00, wa + wb};
      4'd2: return {2'b00, wa - wb};
      4'd3: return {2'b00, wa * wb};
      4'd4: return (b == 16'd0) ? {2'b10, 32'd0} : {2'b00, wa / wb};
      4'd5: return (b == 16'd0) ? {2'b10, 32'd0} : {2'b00, wa % wb};
      default: return 34'd0;
    endcase
  endfunction

  always_comb {alu_error, alu_result} = alu_model(alu_opcode, alu_input1, alu_input2);
  always_comb {d4_alu_error, d4_alu_result} = alu_model(d4_alu_opcode, d4_alu_input1, d4_alu_input2);

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Drive one command on the SETTLE_CYCLES=1 instance and queue its expected response.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input logic [31:0] res, input logic [1:0] err);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    cmd_valid  = 1'b1;
    sb.push_back('{res: res, err: err, tag: tag});
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally apply
  // backpressure for hold cycles, then complete the handshake.
  task automatic get_rsp(input int exp_lat, input int hold);
    int   n;
    exp_t e;
    logic [15:0] in1_before;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    if (exp_lat >= 0) check("rsp_latency", 64'(n), 64'(exp_lat));
    check("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
      check("rsp_error",  {62'd0, rsp_error},  {62'd0, e.err});
      check("rsp_tag",    {60'd0, rsp_tag},    {60'd0, e.tag});
      in1_before = alu_input1;
      for (int i = 0; i < hold; i++) begin
        cmd_opcode = 4'd3; cmd_a = 16'd9; cmd_b = 16'd9; cmd_tag = 4'd15;
        cmd_valid  = 1'b1;
        @(negedge clk);
        check("bp_fields", {26'd0, rsp_valid, rsp_result, rsp_error, rsp_tag},
                           {26'd0, 1'b1, e.res, e.err, e.tag});
        check("bp_ready_busy", {62'd0, cmd_ready, busy}, {62'd0, 1'b0, 1'b1});
        check("bp_ops_hold", 64'(op_count), 64'(exp_ops));
      end
      cmd_valid = 1'b0;
      if (hold > 0) check("bp_alu_untouched", 64'(alu_input1), 64'(in1_before));
      rsp_ready = 1'b1;
      exp_ops  = (exp_ops + 1) % 65536;
      if (e.err != 2'b00 && exp_errs < 255) exp_errs++;
    end
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid_ready", {62'd0, rsp_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});
    check("op_count",  64'(op_count),  64'(exp_ops));
    check("err_count", 64'(err_count), 64'(exp_errs));
  endtask

  initial begin
    int   n;
    logic seen;
    rst_n = 1'b0; d4_rst_n = 1'b0;
    cmd_valid = 1'b0; d4_cmd_valid = 1'b0;
    cmd_opcode = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0; cmd_tag = 4'd0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {61'd0, cmd_ready, rsp_valid, busy}, {61'd0, 3'b100});
    check("rst_alu", {28'd0, alu_input1, alu_input2, alu_opcode}, 64'd0);
    check("rst_rsp", {26'd0, rsp_result, rsp_error, rsp_tag}, 64'd0);
    check("rst_cnt", {40'd0, op_count, err_count}, 64'd0);
    rst_n = 1'b1; d4_rst_n = 1'b1;

    // Add, latency SETTLE_CYCLES+1 with rsp_ready already high.
    send(4'd1, 16'd3, 16'd1, 4'd5, 32'd4, 2'b00);
    check("add_alu_opcode", 64'(alu_opcode), 64'd1);
    check("add_alu_inputs", {32'd0, alu_input1, alu_input2}, {32'd0, 16'd3, 16'd1});
    get_rsp(1, 0);

    // Subtract then multiply back to back.
    send(4'd2, 16'd3, 16'd1, 4'd1, 32'd2, 2'b00);
    check("sub_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    get_rsp(1, 0);
    send(4'd3, 16'd300, 16'd200, 4'd2, 32'd60000, 2'b00);
    get_rsp(1, 0);

    // Divide by zero, then a clean mod.
    send(4'd4, 16'd7, 16'd0, 4'd3, 32'd0, 2'b10);
    get_rsp(1, 0);
    send(4'd5, 16'd7, 16'd3, 4'd4, 32'd1, 2'b00);
    get_rsp(1, 0);

    // Illegal opcode: ALU inputs keep the mod operands, response next cycle.
    send(4'd7, 16'd55, 16'd66, 4'd9, 32'd0, 2'b11);
    check("ill_alu_held", {28'd0, alu_input1, alu_input2, alu_opcode},
                          {28'd0, 16'd7, 16'd3, 4'd5});
    get_rsp(0, 0);

    // Backpressure for 5 cycles with a competing command offered.
    rsp_ready = 1'b0;
    send(4'd1, 16'd1, 16'd2, 4'd6, 32'd3, 2'b00);
    get_rsp(1, 5);
    repeat (2) @(negedge clk);
    check("bp_single_increment", 64'(op_count), 64'(exp_ops));

    // Error counter saturation through a run of illegal opcodes.
    for (int k = 0; k < 258; k++) begin
      send(4'd0, 16'd0, 16'd0, 4'(k), 32'd0, 2'b11);
      get_rsp(0, 0);
    end
    check("err_sat", 64'(err_count), 64'd255);

    // Reset in DRIVE on the SETTLE_CYCLES=4 instance.
    @(negedge clk);
    cmd_opcode = 4'd1; cmd_a = 16'd10; cmd_b = 16'd20; cmd_tag = 4'd3;
    d4_cmd_valid = 1'b1;
    check("d4_ready", {63'd0, d4_cmd_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    d4_cmd_valid = 1'b0;
    check("d4_drive_busy", {47'd0, d4_busy, d4_alu_input1}, {47'd0, 1'b1, 16'd10});
    @(negedge clk);
    d4_rst_n = 1'b0;
    #1;
    check("d4_rst_ctrl", {61'd0, d4_cmd_ready, d4_rsp_valid, d4_busy}, {61'd0, 3'b100});
    check("d4_rst_alu", {28'd0, d4_alu_input1, d4_alu_input2, d4_alu_opcode}, 64'd0);
    check("d4_rst_rsp", {26'd0, d4_rsp_result, d4_rsp_error, d4_rsp_tag}, 64'd0);
    check("d4_rst_cnt", {40'd0, d4_op_count, d4_err_count}, 64'd0);
    @(negedge clk);
    d4_rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | d4_rsp_valid;
    end
    check("d4_no_rsp_after_rst", {63'd0, seen}, 64'd0);

    cmd_opcode = 4'd1; cmd_a = 16'd100; cmd_b = 16'd23; cmd_tag = 4'd4;
    d4_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d4_cmd_valid = 1'b0;
    n = 0;
    while (!d4_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("d4_latency", 64'(n), 64'd4);
    check("d4_rsp", {26'd0, d4_rsp_result, d4_rsp_error, d4_rsp_tag},
                    {26'd0, 32'd123, 2'b00, 4'd4});
    @(posedge clk);
    @(negedge clk);
    check("d4_post_hs", {38'd0, d4_rsp_valid, d4_cmd_ready, d4_op_count, d4_err_count},
                        {38'd0, 1'b0, 1'b1, 16'd1, 8'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
